// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-back write-allocate cache with miss FSM
//   cpu_*  : single-word request/done core port (ready only in IDLE)
//   mem_*  : word-wide req/ack main-memory port for writeback and fill bursts
//   hit_count / miss_count : saturating lookup statistics
module dm_cache_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INDEX_BITS     = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  localparam int OFF_BITS  = $clog2(WORDS_PER_LINE);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS - OFF_BITS - 2;
  localparam int LINES     = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [OFF_BITS-1:0]     wcnt_q, wcnt_d;
  logic                    refill_q, refill_d;
  logic                    done_q, done_d, err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]    hit_q, hit_d, miss_q, miss_d;
  logic [LINES-1:0]        valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0]    tag_mem [LINES];
  logic [31:0]             data_mem [LINES*WORDS_PER_LINE];
  logic                    data_we, tag_we;
  logic [INDEX_BITS+OFF_BITS-1:0] data_wa;
  logic [31:0]             data_wd;
  logic [OFF_BITS-1:0]     word;
  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_WIDTH-1:0]    tag;
  logic                    hit, last;
  assign word      = addr_q[2 +: OFF_BITS];
  assign idx       = addr_q[2+OFF_BITS +: INDEX_BITS];
  assign tag       = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign hit       = valid_q[idx] & (tag_mem[idx] == tag);
  assign last      = wcnt_q == OFF_BITS'(WORDS_PER_LINE-1);
  assign cpu_ready = state_q == IDLE;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign hit_count = hit_q;
  assign miss_count = miss_q;
  // memory outputs decode straight from state so reset drops mem_req at once
  assign mem_req   = (state_q == WB) | (state_q == FILL);
  assign mem_we    = state_q == WB;
  assign mem_addr  = state_q == WB   ? {tag_mem[idx], idx, wcnt_q, 2'b00} :
                     state_q == FILL ? {tag, idx, wcnt_q, 2'b00} : '0;
  assign mem_wdata = state_q == WB ? data_mem[{idx, wcnt_q}] : '0;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wcnt_d   = wcnt_q;
    refill_d = refill_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    hit_d    = hit_q;
    miss_d   = miss_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    data_we  = 1'b0;
    data_wa  = '0;
    data_wd  = '0;
    tag_we   = 1'b0;
    case (state_q)
      IDLE: if (cpu_req) begin
        addr_d  = cpu_addr;
        we_d    = cpu_we;
        wdata_d = cpu_wdata;
        if (|cpu_addr[1:0]) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else state_d = LOOKUP;
      end
      LOOKUP: if (hit) begin
        state_d  = IDLE;
        done_d   = 1'b1;
        refill_d = 1'b0;
        // the lookup that follows a fill was already counted as a miss
        if (!refill_q && !(&hit_q)) hit_d = hit_q + 1'b1;
        if (we_q) begin
          data_we      = 1'b1;
          data_wa      = {idx, word};
          data_wd      = wdata_q;
          dirty_d[idx] = 1'b1;
        end else rdata_d = data_mem[{idx, word}];
      end else begin
        if (!(&miss_q)) miss_d = miss_q + 1'b1;
        wcnt_d       = '0;
        // invalidate now so an interrupted fill never leaves a stale valid line
        valid_d[idx] = 1'b0;
        state_d      = valid_q[idx] & dirty_q[idx] ? WB : FILL;
      end
      WB: if (mem_ack) begin
        wcnt_d = wcnt_q + 1'b1;
        if (last) state_d = FILL;
      end
      FILL: if (mem_ack) begin
        data_we = 1'b1;
        data_wa = {idx, wcnt_q};
        data_wd = mem_rdata;
        wcnt_d  = wcnt_q + 1'b1;
        if (last) begin
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          refill_d     = 1'b1;
          state_d      = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wcnt_q   <= '0;
      refill_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wcnt_q   <= wcnt_d;
      refill_q <= refill_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
    end
  end
  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_wa] <= data_wd;
    if (tag_we) tag_mem[idx] <= tag;
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed scenario bench for dm_cache_ctrl with a word memory model
module tb_dm_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ready, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count, miss_count;
  int vectors = 0, miscompares = 0;
  int ws = 0;
  bit unstable = 0;
  int nlog = 0;
  logic        log_we   [64];
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [31:0] mem [16384];
  dm_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count));
  always #5 clk = ~clk;
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction
  // memory model: acks each word after ws wait cycles, logs every transfer
  initial begin
    bit busy = 0;
    int cnt = 0;
    logic [31:0] ca, cw;
    logic ce;
    logic [13:0] wi;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 16384; i++) mem[i] = pat(32'(i) << 2);
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!busy) begin
          busy = 1; cnt = 0; ca = mem_addr; ce = mem_we; cw = mem_wdata;
        end else if (mem_addr !== ca || mem_we !== ce || (ce && mem_wdata !== cw)) unstable = 1;
        if (cnt == ws) begin
          wi = mem_addr[15:2];
          if (mem_we) mem[wi] = mem_wdata;
          mem_rdata = mem_we ? '0 : mem[wi];
          mem_ack = 1'b1;
          if (nlog < 64) begin
            log_we[nlog] = mem_we; log_addr[nlog] = mem_addr;
            log_data[nlog] = mem_we ? mem_wdata : mem_rdata;
          end
          nlog++;
          busy = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        busy = 0;
      end
    end
  end
  // lat = falling edges from the accept cycle to the cycle showing cpu_done
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lat = 0; rd = 'x; er = 'x;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      lat++;
      if (cpu_done) begin rd = cpu_rdata; er = cpu_err; break; end
    end
    if (!cpu_done) begin
      vectors++; miscompares++;
      $display("FAIL req_timeout addr %h: no cpu_done within 400 cycles", a);
      lat = -1;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", cpu_ready); end
    vectors++; if (cpu_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b exp 0", cpu_done); end
    vectors++; if (cpu_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", cpu_err); end
    vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem got req %b we %b exp 0 0", mem_req, mem_we); end
    vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h exp 0", cpu_rdata); end
    vectors++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin miscompares++; $display("FAIL rst_counts got %h %h exp 0 0", hit_count, miss_count); end
    rst_n = 1'b1;
  endtask
  task automatic test_cold_load;
    logic [31:0] rd; logic er; int lat;
    ws = 0; nlog = 0;
    do_req(1'b0, 32'h0000_1040, 32'h0, rd, er, lat);
    vectors++; if (nlog !== 4) begin miscompares++; $display("FAIL cold_nxfer got %0d exp 4", nlog); end
    for (int i = 0; i < 4 && i < nlog; i++) begin
      vectors++;
      if (log_we[i] !== 1'b0 || log_addr[i] !== 32'h1040 + 32'(4*i)) begin
        miscompares++; $display("FAIL cold_fill%0d got we %b addr %h exp 0 %h", i, log_we[i], log_addr[i], 32'h1040 + 32'(4*i));
      end
    end
    vectors++; if (rd !== pat(32'h1040)) begin miscompares++; $display("FAIL cold_rdata got %h exp %h", rd, pat(32'h1040)); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL cold_err got %b exp 0", er); end
    vectors++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin miscompares++; $display("FAIL cold_counts got hit %0d miss %0d exp 0 1", hit_count, miss_count); end
  endtask
  task automatic test_store_load_hit;
    logic [31:0] rd; logic er; int lat;
    ws = 0; nlog = 0;
    do_req(1'b1, 32'h0000_1044, 32'hDEAD_BEEF, rd, er, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL st_hit_lat got %0d exp 2", lat); end
    do_req(1'b0, 32'h0000_1044, 32'h0, rd, er, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL ld_hit_lat got %0d exp 2", lat); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ld_hit_rdata got %h exp deadbeef", rd); end
    vectors++; if (hit_count !== 16'd2 || miss_count !== 16'd1) begin miscompares++; $display("FAIL hit_counts got hit %0d miss %0d exp 2 1", hit_count, miss_count); end
    vectors++; if (nlog !== 0) begin miscompares++; $display("FAIL hit_nxfer got %0d exp 0", nlog); end
  endtask
  task automatic test_dirty_miss;
    logic [31:0] rd; logic er; int lat; logic [31:0] ea, ed;
    ws = 3; nlog = 0; unstable = 0;
    do_req(1'b0, 32'h0000_2040, 32'h0, rd, er, lat);
    vectors++; if (nlog !== 8) begin miscompares++; $display("FAIL dm_nxfer got %0d exp 8", nlog); end
    for (int i = 0; i < 8 && i < nlog; i++) begin
      ea = (i < 4 ? 32'h1040 : 32'h2040) + 32'(4*(i%4));
      ed = i == 1 ? 32'hDEAD_BEEF : pat(ea);
      vectors++;
      if (log_we[i] !== (i < 4) || log_addr[i] !== ea || (i < 4 && log_data[i] !== ed)) begin
        miscompares++; $display("FAIL dm_xfer%0d got we %b addr %h data %h exp %b %h %h", i, log_we[i], log_addr[i], log_data[i], i < 4, ea, ed);
      end
    end
    vectors++; if (rd !== pat(32'h2040)) begin miscompares++; $display("FAIL dm_rdata got %h exp %h", rd, pat(32'h2040)); end
    vectors++; if (miss_count !== 16'd2 || hit_count !== 16'd2) begin miscompares++; $display("FAIL dm_counts got hit %0d miss %0d exp 2 2", hit_count, miss_count); end
    vectors++; if (unstable !== 1'b0) begin miscompares++; $display("FAIL dm_stable got unstable=%b exp 0", unstable); end
    // 2+16+16+2 = 36 cycles counting both the accept and the done cycle
    vectors++; if (lat !== 35) begin miscompares++; $display("FAIL dm_lat got %0d exp 35 (36 incl. accept cycle)", lat); end
  endtask
  task automatic test_misaligned;
    logic [31:0] rd; logic er; int lat;
    ws = 0; nlog = 0;
    do_req(1'b0, 32'h0000_1042, 32'h0, rd, er, lat);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL mis_err got %b exp 1", er); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL mis_lat got %0d exp 1", lat); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL mis_rdata got %h exp 0", rd); end
    vectors++; if (nlog !== 0) begin miscompares++; $display("FAIL mis_nxfer got %0d exp 0", nlog); end
    vectors++; if (hit_count !== 16'd2 || miss_count !== 16'd2) begin miscompares++; $display("FAIL mis_counts got hit %0d miss %0d exp 2 2", hit_count, miss_count); end
  endtask
  task automatic test_reset_mid_fill;
    logic [31:0] rd; logic er; int lat;
    ws = 3; nlog = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3040;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 100 && nlog < 1; i++) @(negedge clk);
    vectors++; if (nlog !== 1) begin miscompares++; $display("FAIL rmf_first_word got %0d xfers exp 1", nlog); end
    @(posedge clk);
    #2;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h3044) begin miscompares++; $display("FAIL rmf_word2 got req %b addr %h exp 1 3044", mem_req, mem_addr); end
    rst_n = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rmf_req_drop got %b exp 0", mem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    ws = 0; nlog = 0;
    do_req(1'b0, 32'h0000_3040, 32'h0, rd, er, lat);
    vectors++; if (nlog !== 4) begin miscompares++; $display("FAIL rmf_refill got %0d xfers exp 4", nlog); end
    vectors++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin miscompares++; $display("FAIL rmf_counts got hit %0d miss %0d exp 0 1", hit_count, miss_count); end
    vectors++; if (rd !== pat(32'h3040)) begin miscompares++; $display("FAIL rmf_rdata got %h exp %h", rd, pat(32'h3040)); end
  endtask
  initial begin
    test_reset();
    test_cold_load();
    test_store_load_hit();
    test_dirty_miss();
    test_misaligned();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
